// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector between ID and EX: combinational stall plus a registered stall history.
// Optional stall-cycle counter on stall_cnt is enabled by defining HDU_PERF_CNT_EN.
module hazard_detection_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_rs1,
    input  logic [REG_ADDR_W-1:0] ID_rs2,
    input  logic [REG_ADDR_W-1:0] EX_rd,
    input  logic                  EX_memRead,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_flush,
`ifdef HDU_PERF_CNT_EN
    output logic [CNT_W-1:0]      stall_cnt,
`endif
    output logic                  stall_prev
);

    logic rd_nonzero;
    logic src_match;
    logic stall_prev_q;

    // x0 is hardwired to zero, so a load targeting it can never feed a dependent instruction.
    assign rd_nonzero = |EX_rd;
    assign src_match  = (EX_rd == ID_rs1) || (EX_rd == ID_rs2);

    always_comb begin
        stall      = EX_memRead & rd_nonzero & src_match;
        pc_write   = ~stall;
        ifid_write = ~stall;
        idex_flush = stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_prev_q <= 1'b0;
        end else begin
            stall_prev_q <= stall;
        end
    end

    assign stall_prev = stall_prev_q;

`ifdef HDU_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // CNT_W only sizes the optional counter; keep it referenced in the default build.
    if (CNT_W == 0) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit using expected-value queues.
// Counter scenarios run only when HDU_PERF_CNT_EN is defined (counter built with CNT_W=4).
module tb_hazard_detection_unit;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [RW-1:0] ID_rs1;
    logic [RW-1:0] ID_rs2;
    logic [RW-1:0] EX_rd;
    logic          EX_memRead;
    logic          stall;
    logic          pc_write;
    logic          ifid_write;
    logic          idex_flush;
    logic          stall_prev;
`ifdef HDU_PERF_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // {stall, pc_write, ifid_write, idex_flush}
    logic [3:0] comb_q[$];
    logic       prev_q[$];

    hazard_detection_unit #(
        .REG_ADDR_W(RW),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ID_rs1    (ID_rs1),
        .ID_rs2    (ID_rs2),
        .EX_rd     (EX_rd),
        .EX_memRead(EX_memRead),
        .stall     (stall),
        .pc_write  (pc_write),
        .ifid_write(ifid_write),
        .idex_flush(idex_flush),
`ifdef HDU_PERF_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .stall_prev(stall_prev)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector and push the outputs it must produce.
    task automatic drive(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic [RW-1:0] rd, input logic mr);
        logic s;
        ID_rs1     = rs1;
        ID_rs2     = rs2;
        EX_rd      = rd;
        EX_memRead = mr;
        s = 1'b0;
        if (mr && rd != 0) begin
            if (rd == rs1 || rd == rs2) s = 1'b1;
        end
        comb_q.push_back({s, !s, !s, s});
        prev_q.push_back(s);
    endtask

    task automatic test_reset();
        logic [3:0] e;
        rst = 1'b1;
        drive(5'd1, 5'd2, 5'd3, 1'b0);
        void'(prev_q.pop_back());
        #3;
        checks++;
        if (stall_prev !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_prev got=%b want=0", stall_prev);
        end
        e = comb_q.pop_front();
        checks++;
        if ({stall, pc_write, ifid_write, idex_flush} !== e) begin
            errors++;
            $display("FAIL reset_comb got=%b want=%b",
                     {stall, pc_write, ifid_write, idex_flush}, e);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Directed comb vectors; each also checked for stall_prev after the next edge.
    task automatic test_directed();
        logic [3:0] e;
        logic       p;
        logic [RW-1:0] vec [0:5][0:2];
        logic          mrv [0:5];
        vec[0] = '{5'd1, 5'd2, 5'd3}; mrv[0] = 1'b1;  // no match
        vec[1] = '{5'd1, 5'd2, 5'd1}; mrv[1] = 1'b1;  // rs1 match
        vec[2] = '{5'd1, 5'd2, 5'd2}; mrv[2] = 1'b1;  // rs2 match
        vec[3] = '{5'd4, 5'd4, 5'd4}; mrv[3] = 1'b1;  // both match
        vec[4] = '{5'd4, 5'd4, 5'd4}; mrv[4] = 1'b0;  // not a load
        vec[5] = '{5'd0, 5'd0, 5'd0}; mrv[5] = 1'b1;  // x0 guard
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(vec[i][0], vec[i][1], vec[i][2], mrv[i]);
            #1;
            e = comb_q.pop_front();
            checks++;
            if ({stall, pc_write, ifid_write, idex_flush} !== e) begin
                errors++;
                $display("FAIL directed_%0d got=%b want=%b", i,
                         {stall, pc_write, ifid_write, idex_flush}, e);
            end
            @(posedge clk);
            #1;
            p = prev_q.pop_front();
            checks++;
            if (stall_prev !== p) begin
                errors++;
                $display("FAIL directed_prev_%0d got=%b want=%b", i, stall_prev, p);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(5'd7, 5'd9, 5'd7, 1'b1);
        void'(comb_q.pop_front());
        @(posedge clk);
        #1;
        checks++;
        if (stall_prev !== prev_q.pop_front()) begin
            errors++;
            $display("FAIL async_pre got=%b want=1", stall_prev);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (stall_prev !== 1'b0) begin
            errors++;
            $display("FAIL async_clear got=%b want=0", stall_prev);
        end
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL async_stall_indep got=%b want=1", stall);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(5'd7, 5'd9, 5'd9, 1'b1);
        void'(comb_q.pop_front());
        @(posedge clk);
        #1;
        checks++;
        if (stall_prev !== prev_q.pop_front()) begin
            errors++;
            $display("FAIL async_release got=%b want=1", stall_prev);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        logic       p;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                  RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            #1;
            e = comb_q.pop_front();
            checks++;
            if ({stall, pc_write, ifid_write, idex_flush} !== e) begin
                errors++;
                $display("FAIL b2b_comb_%0d got=%b want=%b", i,
                         {stall, pc_write, ifid_write, idex_flush}, e);
            end
            @(posedge clk);
            #1;
            p = prev_q.pop_front();
            checks++;
            if (stall_prev !== p) begin
                errors++;
                $display("FAIL b2b_prev_%0d got=%b want=%b", i, stall_prev, p);
            end
        end
    endtask

`ifdef HDU_PERF_CNT_EN
    task automatic run_edges(input int n, input logic s);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (s) drive(5'd3, 5'd0, 5'd3, 1'b1);
            else   drive(5'd3, 5'd0, 5'd3, 1'b0);
            void'(comb_q.pop_front());
            void'(prev_q.pop_front());
            @(posedge clk);
        end
    endtask

    task automatic test_perf_cnt();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL cnt_reset got=%0d want=0", stall_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        run_edges(3, 1'b1);
        run_edges(2, 1'b0);
        #1;
        checks++;
        if (stall_cnt !== 4'd3) begin
            errors++;
            $display("FAIL cnt_3_2 got=%0d want=3", stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_edges(15, 1'b1);
        #1;
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL cnt_full got=%0d want=15", stall_cnt);
        end
        run_edges(1, 1'b1);
        #1;
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL cnt_wrap got=%0d want=0", stall_cnt);
        end
    endtask
`endif

    initial begin
        rst        = 1'b0;
        ID_rs1     = '0;
        ID_rs2     = '0;
        EX_rd      = '0;
        EX_memRead = 1'b0;
        test_reset();
        test_directed();
        test_async_reset();
        test_back_to_back();
`ifdef HDU_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Load-use hazard detector for the RV32IM 5-stage pipeline, located between ID and EX.
- Compares the ID-stage source registers against the destination of a load in EX.
- On a match, asserts a combinational stall, freezes PC and IF/ID, and flushes ID/EX (inserts a bubble).
- Holds a small clocked block for stall history and an optional performance counter.

Parameters:
- REG_ADDR_W, 5, register-index width (x0..x31).
- CNT_W, 32, width of the stall performance counter; used only when the optional feature is enabled.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ID_rs1  input  5  rs1 index of the instruction in ID.
- ID_rs2  input  5  rs2 index of the instruction in ID.
- EX_rd  input  5  rd index of the instruction in EX.
- EX_memRead  input  1  high when the EX instruction is a load.
- stall  output  1  combinational load-use stall request.
- pc_write  output  1  equals ~stall; PC update enable.
- ifid_write  output  1  equals ~stall; IF/ID register write enable.
- idex_flush  output  1  equals stall; zeroes ID/EX control (bubble).
- stall_prev  output  1  registered copy of stall from the previous cycle.
- stall_cnt  output  CNT_W  stall-cycle counter; present only when HDU_PERF_CNT_EN is defined.

Behaviour:
- stall = EX_memRead & (EX_rd != 0) & ((EX_rd == ID_rs1) | (EX_rd == ID_rs2)).
- stall is purely combinational: zero latency, settles within the same cycle as input changes, and is independent of clk and rst.
- A match on rs1, on rs2, or on both gives the same result, stall=1.
- x0 guard: when EX_rd == 0, stall=0 regardless of ID_rs1, ID_rs2 or EX_memRead, including the case rs1=rs2=rd=0.
- When EX_memRead=0, stall=0 even if the indices match (ALU results are covered by the forwarding unit).
- pc_write, ifid_write and idex_flush are combinational functions of stall only.
- stall_prev:
  - Cleared to 0 asynchronously while rst=1.
  - Otherwise takes the value of stall on each rising clk edge.
- Nothing is sequenced inside the block. Stall duration follows the pipeline naturally: the bubble clears EX_memRead on the next cycle, so a single load-use produces exactly one stall cycle.
- X/Z inputs are not handled specially. Drivers must present known values whenever rst=0.

Optional Feature:
- Macro: HDU_PERF_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - Reset asynchronously to 0 while rst=1.
  - Increments by 1 on every rising clk edge where stall=1.
  - Wraps modulo 2^CNT_W (all-ones + 1 gives 0).
  - Holds its value when stall=0.
- Undefined:
  - stall_cnt port and its register are absent.
  - All other behaviour is identical.

Test Plan:
- ID_rs1=1, ID_rs2=2, EX_rd=3, EX_memRead=1 -> stall=0, pc_write=1, ifid_write=1, idex_flush=0.
- EX_rd=1, others as above -> stall=1, pc_write=0, ifid_write=0, idex_flush=1. Then EX_rd=2 -> stall=1.
- ID_rs1=4, ID_rs2=4, EX_rd=4, EX_memRead=1 -> stall=1. Then set EX_memRead=0 -> stall=0.
- EX_rd=0, ID_rs1=0, ID_rs2=0, EX_memRead=1 -> stall=0 (x0 never stalls).
- Assert rst mid-cycle while stall=1 -> stall_prev goes to 0 immediately, with no clk edge needed. Release rst, then clock with stall=1 -> stall_prev=1 after the next rising edge.
- With HDU_PERF_CNT_EN: hold stall=1 for 3 edges, then stall=0 for 2 edges -> stall_cnt=3. Preload via 2^CNT_W-1 stall edges in a short-CNT_W build (CNT_W=4: 15 edges), then 1 more -> stall_cnt=0.
